// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 target receiver.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    localparam int SPI_BITS = 8;
    localparam int CNT_W    = $clog2(SPI_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_BITS - 1);

    // Pin levels seen while the link is idle.
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_N_IDLE = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;
    localparam logic DC_IDLE   = 1'b0;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for an asynchronous pin, with registered edge strobes.
module spi_pin_sync #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= {STAGES{IDLE_LEVEL}};
            prev <= IDLE_LEVEL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], pin};
            prev <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~prev;
            fall <= ~sync[STAGES-1] & prev;
        end
    end

    // level is taken after the edge register so it lines up with the strobes.
    assign level = prev;

endmodule

// File: rtl/spi_target_rx.sv
// SPI mode-0 target: oversampled pins, MSB-first byte capture with D/C tag,
// one-entry holding register and a preloadable MISO return byte.
module spi_target_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int MIN_HALF_PERIOD = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_clk_in,
    input  logic       spi_mosi_in,
    input  logic       spi_cs_n_in,
    input  logic       lcd_dc_in,
    output logic       spi_miso,
    output logic [7:0] rx_data,
    output logic       rx_dc,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic       frame_err,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       busy
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic dc_s, dc_rise, dc_fall;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(SCLK_IDLE)) u_sclk (
        .clk(clk), .reset_n(reset_n), .pin(spi_clk_in),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(CS_N_IDLE)) u_cs (
        .clk(clk), .reset_n(reset_n), .pin(spi_cs_n_in),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(MOSI_IDLE)) u_mosi (
        .clk(clk), .reset_n(reset_n), .pin(spi_mosi_in),
        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(DC_IDLE)) u_dc (
        .clk(clk), .reset_n(reset_n), .pin(lcd_dc_in),
        .level(dc_s), .rise(dc_rise), .fall(dc_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_level, cs_level, mosi_rise, mosi_fall,
                           dc_rise, dc_fall, (MIN_HALF_PERIOD != 0)};

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SPI_BITS-1:0] rx_shift;
    logic [SPI_BITS-1:0] tx_shift;
    logic [SPI_BITS-1:0] tx_hold;
    logic                dc_cap;
    logic                byte_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            tx_hold    <= '0;
            dc_cap     <= 1'b0;
            byte_done  <= 1'b0;
            spi_miso   <= 1'b0;
            rx_data    <= '0;
            rx_dc      <= 1'b0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            if (tx_load)
                tx_hold <= tx_data;

            if (rx_ack && rx_valid)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= SHIFT;
                        bit_cnt   <= '0;
                        tx_shift  <= tx_hold;
                        spi_miso  <= tx_hold[SPI_BITS-1];
                        byte_done <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        spi_miso  <= 1'b0;
                        byte_done <= 1'b0;
                        bit_cnt   <= '0;
                        if (bit_cnt != '0)
                            frame_err <= 1'b1;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[SPI_BITS-2:0], mosi_s};
                            dc_cap   <= dc_s;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT)
                                state <= COMPLETE;
                        end
                        // First falling edge after a finished byte starts the next return byte.
                        if (sclk_fall) begin
                            if (byte_done) begin
                                tx_shift  <= tx_hold;
                                spi_miso  <= tx_hold[SPI_BITS-1];
                                byte_done <= 1'b0;
                            end else begin
                                tx_shift <= {tx_shift[SPI_BITS-2:0], 1'b0};
                                spi_miso <= tx_shift[SPI_BITS-2];
                            end
                        end
                    end
                end

                COMPLETE: begin
                    rx_data   <= rx_shift;
                    rx_dc     <= dc_cap;
                    rx_valid  <= 1'b1;
                    bit_cnt   <= '0;
                    byte_done <= 1'b1;
                    if (rx_valid && !rx_ack)
                        rx_overrun <= 1'b1;
                    if (cs_rise) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        spi_miso  <= 1'b0;
                        byte_done <= 1'b0;
                    end else begin
                        state <= SHIFT;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
